alu_issue_ctrl: RTL and testbench



---
 rtl/alu_issue_ctrl_pkg.sv | 39 +++
 rtl/alu_issue_ctrl_if.sv | 32 +++
 rtl/alu_issue_pc.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared definitions for the ALU issue controller.
//   - ALU_ABC opcode encoding (kADDL..kSLO are the register-writing ALU ops,
//     kBL/kBMH are branches, 10..14 are undefined, kHALT stops execution)
//   - issue_state_t: controller FSM states
//   - pc_sel_t: next-PC selection used by alu_issue_pc
//   - helper functions classifying opcodes
package alu_issue_ctrl_pkg;

  localparam logic [3:0] kADDL = 4'h0;
  localparam logic [3:0] kSUB  = 4'h1;
  localparam logic [3:0] kAND  = 4'h2;
  localparam logic [3:0] kXOR  = 4'h3;
  localparam logic [3:0] kNOT  = 4'h4;
  localparam logic [3:0] kSRG  = 4'h5;
  localparam logic [3:0] kSLG  = 4'h6;
  localparam logic [3:0] kSLO  = 4'h7;
  localparam logic [3:0] kBL   = 4'h8;
  localparam logic [3:0] kBMH  = 4'h9;
  localparam logic [3:0] kHALT = 4'hF;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WB, HALT} issue_state_t;

  typedef enum logic [1:0] {PC_HOLD, PC_INC, PC_OFFSET, PC_LOAD} pc_sel_t;

  // ALU ops occupy the contiguous range starting at opcode 0.
  function automatic logic is_alu_op(input logic [3:0] op);
    return op <= kSLO;
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == kBL) || (op == kBMH);
  endfunction

  // Only the add and the two general shifts produce a carry worth keeping.
  function automatic logic writes_carry(input logic [3:0] op);
    return (op == kADDL) || (op == kSRG) || (op == kSLG);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: bus between the issue controller and its neighbours.
//   pc                        : instruction ROM address
//   instr                     : instruction word from ROM (combinational)
//   op, sc_in                 : ALU opcode and carry/shift in
//   sc_out, br_flag           : ALU carry/shift out and branch-taken flag
//   ra_addr, rb_addr          : register-file read addresses (ALU A / B)
//   wr_addr, rf_we            : register-file write address and enable
// master = controller side, slave = ROM/ALU/register-file side.
interface alu_issue_ctrl_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] pc;
  logic [8:0]      instr;
  logic [3:0]      op;
  logic            sc_in;
  logic            sc_out;
  logic            br_flag;
  logic [2:0]      ra_addr;
  logic [2:0]      rb_addr;
  logic [2:0]      wr_addr;
  logic            rf_we;

  modport master (
    output pc, op, sc_in, ra_addr, rb_addr, wr_addr, rf_we,
    input  instr, sc_out, br_flag
  );

  modport slave (
    input  pc, op, sc_in, ra_addr, rb_addr, wr_addr, rf_we,
    output instr, sc_out, br_flag
  );
endinterface

// File: rtl/alu_issue_pc.sv
// alu_issue_pc: program counter register with next-PC mux.
//   clk, reset_n : clock, synchronous active-low reset (loads START_PC)
//   sel          : hold / +1 / +sign-extended offset / load START_PC
//   offset       : signed 5-bit branch offset
//   pc           : current program counter, wraps modulo 2^PC_W
module alu_issue_pc
  import alu_issue_ctrl_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  pc_sel_t         sel,
  input  logic [4:0]      offset,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_nxt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    pc_nxt = pc;
    unique case (sel)
      PC_INC:    pc_nxt = pc + PC_W'(1);
      PC_OFFSET: pc_nxt = pc + {{(PC_W-5){offset[4]}}, offset};
      PC_LOAD:   pc_nxt = START_PC;
      default:   pc_nxt = pc;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) pc <= START_PC;
    else          pc <= pc_nxt;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: three-cycle (FETCH/EXEC/WB) issue controller for ALU_ABC.
//   clk, reset_n : clock, synchronous active-low reset
//   start        : one-cycle pulse, starts from START_PC when idle or halted
//   bus          : master side of alu_issue_ctrl_if (ROM, ALU, register file)
//   done         : high while halted
//   cycle_cnt    : busy-cycle counter, present only when the macro
//                  ALU_ISSUE_CYCLE_COUNT_EN is defined
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter logic [3:0]      HALT_OP  = kHALT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  alu_issue_ctrl_if.master      bus,
  output logic                  done
`ifdef ALU_ISSUE_CYCLE_COUNT_EN
  ,
  output logic [15:0]           cycle_cnt
`endif
);

  issue_state_t    state, state_nxt;
  logic [8:0]      ir;
  logic [3:0]      ir_op;
  logic            carry;
  logic            sc_smp;
  logic            br_smp;
  logic            start_acc;
  pc_sel_t         pc_sel;
  logic [PC_W-1:0] pc;
  logic [3:0]      op;
  logic [2:0]      ra_addr, rb_addr, wr_addr;
  logic            rf_we;

  assign ir_op     = ir[8:5];
  assign start_acc = start && ((state == IDLE) || (state == HALT));

  alu_issue_pc #(.PC_W(PC_W), .START_PC(START_PC)) u_pc (
    .clk    (clk),
    .reset_n(reset_n),
    .sel    (pc_sel),
    .offset (ir[4:0]),
    .pc     (pc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, HALT: if (start) state_nxt = FETCH;
      FETCH:      state_nxt = EXEC;
      EXEC:       state_nxt = WB;
      WB:         state_nxt = (ir_op == HALT_OP) ? HALT : FETCH;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    pc_sel  = PC_HOLD;
    op      = '0;
    ra_addr = '0;
    rb_addr = '0;
    wr_addr = '0;
    rf_we   = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: if (start) pc_sel = PC_LOAD;
      HALT: begin
        done = 1'b1;
        if (start) pc_sel = PC_LOAD;
      end
      EXEC: begin
        op = ir_op;
        if (is_alu_op(ir_op)) begin
          ra_addr = ir[4:2];
          rb_addr = {1'b0, ir[1:0]};
        end else if (is_branch(ir_op)) begin
          ra_addr = 3'd0;
          rb_addr = 3'd1;
        end
      end
      WB: begin
        if (ir_op == HALT_OP) begin
          pc_sel = PC_HOLD;
        end else if (is_alu_op(ir_op)) begin
          // Reset asserted during WB must suppress the write in that same
          // cycle, so the enable is gated by the reset input directly.
          rf_we   = reset_n;
          wr_addr = ir[4:2];
          pc_sel  = PC_INC;
        end else if (is_branch(ir_op)) begin
          pc_sel = br_smp ? PC_OFFSET : PC_INC;
        end else begin
          pc_sel = PC_INC;
        end
      end
      default: ;
    endcase
  end

  // Instruction register, ALU result samples and carry flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ir     <= '0;
      carry  <= 1'b0;
      sc_smp <= 1'b0;
      br_smp <= 1'b0;
    end else begin
      if (start_acc) carry <= 1'b0;
      if (state == FETCH) ir <= bus.instr;
      if (state == EXEC) begin
        sc_smp <= bus.sc_out;
        // ALU_ABC leaves br_flag stale for non-branch ops.
        br_smp <= is_branch(ir_op) && bus.br_flag;
      end
      if ((state == WB) && writes_carry(ir_op)) carry <= sc_smp;
    end
  end

`ifdef ALU_ISSUE_CYCLE_COUNT_EN
  logic running;
  assign running = (state == FETCH) || (state == EXEC) || (state == WB);

  always_ff @(posedge clk) begin
    if (!reset_n)                          cycle_cnt <= '0;
    else if (start_acc)                    cycle_cnt <= '0;
    else if (running && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 16'd1;
  end
`endif

  assign bus.pc      = pc;
  assign bus.op      = op;
  assign bus.sc_in   = carry;
  assign bus.ra_addr = ra_addr;
  assign bus.rb_addr = rb_addr;
  assign bus.wr_addr = wr_addr;
  assign bus.rf_we   = rf_we;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: self-checking bench for alu_issue_ctrl.
// The bench plays the ROM (returns the instruction for the expected PC) and
// the ALU (drives sc_out/br_flag). A directed program table, a randomized
// instruction stream checked against an instruction-level model, and a few
// hand-written reset/start/halt sequences exercise the controller.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic clk;
  logic reset_n;
  logic start;
  logic done;
`ifdef ALU_ISSUE_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt;
`endif

  int total = 0;
  int bad   = 0;

  alu_issue_ctrl_if #(.PC_W(8)) bus ();

  alu_issue_ctrl #(.PC_W(8), .START_PC(8'h00), .HALT_OP(4'hF)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus.master),
    .done     (done)
`ifdef ALU_ISSUE_CYCLE_COUNT_EN
    ,
    .cycle_cnt(cycle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [8:0] ins;
    logic       sc;
    logic       br;
    int         pc;   // expected PC while fetching this instruction
    logic       we;   // register write expected in WB
    logic [2:0] wa;
    int         nx;   // expected PC of the next fetch
    logic       c;    // expected carry after the instruction
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Runs one instruction starting #1 after the edge that entered FETCH and
  // returns #1 after the edge that leaves WB.
  task automatic exec_one(input logic [8:0] ins, input logic sc, input logic br,
                          input logic poke, input int exp_pc, input logic exp_we,
                          input logic [2:0] exp_wa, input int exp_nx, input logic exp_c);
    logic [3:0] opc;
    logic [2:0] e_ra, e_rb;
    logic       known;
    opc   = ins[8:5];
    known = 1'b0;
    e_ra  = 3'd0;
    e_rb  = 3'd0;
    if (opc <= 4'd7) begin
      known = 1'b1;
      e_ra  = ins[4:2];
      e_rb  = {1'b0, ins[1:0]};
    end else if (opc == kBL || opc == kBMH) begin
      known = 1'b1;
      e_rb  = 3'd1;
    end
    // FETCH
    start = poke;
    check("fetch_pc", bus.pc, exp_pc);
    check("fetch_we", bus.rf_we, 0);
    check("fetch_done", done, 0);
    bus.instr   = ins;
    bus.sc_out  = 1'($urandom);
    bus.br_flag = 1'($urandom);
    step();
    // EXEC
    check("exec_op", bus.op, opc);
    check("exec_we", bus.rf_we, 0);
    if (known) begin
      check("exec_ra", bus.ra_addr, e_ra);
      check("exec_rb", bus.rb_addr, e_rb);
    end
    bus.instr   = 9'($urandom);
    bus.sc_out  = sc;
    bus.br_flag = br;
    step();
    // WB
    check("wb_we", bus.rf_we, exp_we);
    if (exp_we) check("wb_wa", bus.wr_addr, exp_wa);
    bus.sc_out  = ~sc;
    bus.br_flag = ~br;
    step();
    start = 1'b0;
    if (opc == 4'hF) begin
      check("halt_done", done, 1);
      check("halt_pc", bus.pc, exp_pc);
      check("halt_we", bus.rf_we, 0);
    end else begin
      check("next_pc", bus.pc, exp_nx);
      check("carry", bus.sc_in, exp_c);
      check("next_done", done, 0);
    end
  endtask

  initial begin
    int m_pc;
    logic m_c;

    // Directed program: carry chain, branches both ways, wrap, self-loop,
    // undefined opcode, halt.
    tbl[0]  = '{{kADDL, 3'd2, 2'd1}, 1'b1, 1'b1, 8'h00, 1'b1, 3'd2, 8'h01, 1'b1};
    tbl[1]  = '{{kXOR,  3'd3, 2'd0}, 1'b0, 1'b1, 8'h01, 1'b1, 3'd3, 8'h02, 1'b1};
    tbl[2]  = '{{kBL,   5'b11100},   1'b0, 1'b1, 8'h02, 1'b0, 3'd0, 8'hFE, 1'b1};
    tbl[3]  = '{{kNOT,  3'd1, 2'd2}, 1'b0, 1'b0, 8'hFE, 1'b1, 3'd1, 8'hFF, 1'b1};
    tbl[4]  = '{{kNOT,  3'd5, 2'd3}, 1'b1, 1'b1, 8'hFF, 1'b1, 3'd5, 8'h00, 1'b1};
    tbl[5]  = '{{kBMH,  5'b00010},   1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h01, 1'b1};
    tbl[6]  = '{{kSRG,  3'd4, 2'd3}, 1'b0, 1'b1, 8'h01, 1'b1, 3'd4, 8'h02, 1'b0};
    tbl[7]  = '{{kBL,   5'b00000},   1'b1, 1'b1, 8'h02, 1'b0, 3'd0, 8'h02, 1'b0};
    tbl[8]  = '{{kBL,   5'b11100},   1'b1, 1'b0, 8'h02, 1'b0, 3'd0, 8'h03, 1'b0};
    tbl[9]  = '{{4'd12, 5'b10101},   1'b1, 1'b1, 8'h03, 1'b0, 3'd0, 8'h04, 1'b0};
    tbl[10] = '{{kSLG,  3'd7, 2'd0}, 1'b1, 1'b0, 8'h04, 1'b1, 3'd7, 8'h05, 1'b1};
    tbl[11] = '{{kBMH,  5'b01111},   1'b0, 1'b1, 8'h05, 1'b0, 3'd0, 8'h14, 1'b1};
    tbl[12] = '{{kSLO,  3'd6, 2'd2}, 1'b0, 1'b0, 8'h14, 1'b1, 3'd6, 8'h15, 1'b1};
    tbl[13] = '{{kHALT, 5'd0},       1'b0, 1'b0, 8'h15, 1'b0, 3'd0, 8'h15, 1'b1};

    reset_n     = 1'b0;
    start       = 1'b0;
    bus.instr   = '0;
    bus.sc_out  = 1'b0;
    bus.br_flag = 1'b0;
    step();
    step();
    check("rst_pc", bus.pc, 0);
    check("rst_we", bus.rf_we, 0);
    check("rst_done", done, 0);
    check("rst_op", bus.op, 0);
    check("rst_ra", bus.ra_addr, 0);
    check("rst_rb", bus.rb_addr, 0);
    check("rst_wa", bus.wr_addr, 0);
    check("rst_carry", bus.sc_in, 0);
    reset_n = 1'b1;
    step();
    check("idle_pc", bus.pc, 0);
    check("idle_done", done, 0);

    pulse_start();
    for (int i = 0; i < 14; i++)
      exec_one(tbl[i].ins, tbl[i].sc, tbl[i].br, 1'b0, tbl[i].pc,
               tbl[i].we, tbl[i].wa, tbl[i].nx, tbl[i].c);

    // HALT holds; START restarts with PC reloaded and carry cleared.
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_done", done, 1);
      check("hold_pc", bus.pc, 8'h15);
      check("hold_we", bus.rf_we, 0);
    end
    pulse_start();
    check("restart_pc", bus.pc, 0);
    check("restart_done", done, 0);
    check("restart_carry", bus.sc_in, 0);

    // Randomized stream against an instruction-level model; START is poked
    // at random while running and must be ignored.
    m_pc = 0;
    m_c  = 1'b0;
    for (int i = 0; i < 80; i++) begin
      logic [8:0] ins;
      logic [3:0] opc;
      logic       sc, br, alu;
      int         off, nx;
      opc = 4'($urandom_range(0, 14));
      ins = {opc, 5'($urandom)};
      sc  = 1'($urandom);
      br  = 1'($urandom);
      alu = (opc <= 4'd7);
      off = ins[4] ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
      if ((opc == kBL || opc == kBMH) && br) nx = (m_pc + off + 256) % 256;
      else                                   nx = (m_pc + 1) % 256;
      if (opc == kADDL || opc == kSRG || opc == kSLG) m_c = sc;
      exec_one(ins, sc, br, ($urandom_range(0, 3) == 0), m_pc, alu, ins[4:2], nx, m_c);
      m_pc = nx;
    end
    exec_one({kHALT, 5'd0}, 1'b0, 1'b0, 1'b1, m_pc, 1'b0, 3'd0, m_pc, m_c);

    // Two-instruction program from HALT.
    pulse_start();
`ifdef ALU_ISSUE_CYCLE_COUNT_EN
    check("cnt_clear", cycle_cnt, 0);
`endif
    exec_one({kADDL, 3'd1, 2'd2}, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 8'h01, 1'b0);
    exec_one({kHALT, 5'd0}, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 3'd0, 8'h01, 1'b0);
`ifdef ALU_ISSUE_CYCLE_COUNT_EN
    check("cnt_halt", cycle_cnt, 6);
    step();
    step();
    check("cnt_hold", cycle_cnt, 6);
`endif

    // Reset during WB of an ALU op: no write, back to IDLE with PC=0.
    pulse_start();
    exec_one({kADDL, 3'd2, 2'd1}, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 8'h01, 1'b1);
    bus.instr = {kADDL, 3'd3, 2'd0};
    step();
    bus.sc_out = 1'b0;
    step();
    check("pre_rst_we", bus.rf_we, 1);
    reset_n = 1'b0;
    #1;
    check("rst_wb_we", bus.rf_we, 0);
    step();
    check("rst_wb_pc", bus.pc, 0);
    check("rst_wb_carry", bus.sc_in, 0);
    check("rst_wb_op", bus.op, 0);
    check("rst_wb_done", done, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_stay_we", bus.rf_we, 0);
      check("idle_stay_pc", bus.pc, 0);
    end
    pulse_start();
    exec_one({kHALT, 5'd0}, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
